// File: rtl/nibble_compare_seq.sv
// ---------------------------------------------------------------------------
// nibble_compare_seq
//
// Purpose:
//   Compares two multi-nibble words with one shared 4-bit equality
//   comparator. Each RUN cycle handles one nibble, lowest nibble first. The
//   result is overall equality plus the index of the lowest mismatching
//   nibble. A host launches a compare with start and waits for done.
//
// Optional build macro:
//   CMP_EARLY_EXIT_EN - if defined, the scan stops at the first mismatching
//                       nibble, so latency depends on the data. If undefined,
//                       every nibble is always scanned and latency is fixed.
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   start        - request a compare; only sampled while idle
//   a_word       - operand A, captured on the accepting edge
//   b_word       - operand B, captured on the accepting edge
//   busy         - high while nibbles are being compared
//   done         - one-cycle pulse that marks a valid result
//   equal        - 1 when all compared nibbles matched; held until next done
//   mismatch_idx - lowest mismatching nibble index; 0 when equal
// ---------------------------------------------------------------------------
module nibble_compare_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [4*NIBBLES-1:0]       a_word,
    input  logic [4*NIBBLES-1:0]       b_word,
    output logic                       busy,
    output logic                       done,
    output logic                       equal,
    output logic [$clog2(NIBBLES)-1:0] mismatch_idx
);

    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [4*NIBBLES-1:0] r_aWord;
    logic [4*NIBBLES-1:0] r_bWord;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_found;
    logic [IDX_W-1:0]     r_firstIdx;
    logic                 r_equal;
    logic [IDX_W-1:0]     r_misIdx;

    logic [4*NIBBLES-1:0] w_shiftA;
    logic [4*NIBBLES-1:0] w_shiftB;
    logic                 w_nibMis;
    logic                 w_accept;
    logic                 w_leave;

    // Shift the current nibble down to bit 0. The shift amount is idx*4, so
    // the comparator always reads bits [3:0].
    assign w_shiftA = r_aWord >> {r_idx, 2'b00};
    assign w_shiftB = r_bWord >> {r_idx, 2'b00};
    assign w_nibMis = (w_shiftA[3:0] != w_shiftB[3:0]);

    assign w_accept = (r_state == IDLE) && start;

`ifdef CMP_EARLY_EXIT_EN
    assign w_leave = (r_state == RUN) && ((r_idx == LAST_IDX) || w_nibMis);
`else
    assign w_leave = (r_state == RUN) && (r_idx == LAST_IDX);
`endif

    assign busy         = (r_state == RUN);
    assign done         = (r_state == DONE);
    assign equal        = r_equal;
    assign mismatch_idx = r_misIdx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. DONE always lasts one cycle, and start is ignored
    // everywhere except IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start)   w_nextState = RUN;
            RUN:     if (w_leave) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath. r_found keeps the first mismatch, so later mismatches cannot
    // replace it. The nibble compared on the leaving edge is folded straight
    // into the published result, because r_found has not yet captured it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aWord    <= '0;
            r_bWord    <= '0;
            r_idx      <= '0;
            r_found    <= 1'b0;
            r_firstIdx <= '0;
            r_equal    <= 1'b0;
            r_misIdx   <= '0;
        end else if (w_accept) begin
            r_aWord    <= a_word;
            r_bWord    <= b_word;
            r_idx      <= '0;
            r_found    <= 1'b0;
            r_firstIdx <= '0;
        end else if (r_state == RUN) begin
            if (!r_found && w_nibMis) begin
                r_found    <= 1'b1;
                r_firstIdx <= r_idx;
            end
            if (w_leave) begin
                r_equal <= !(r_found || w_nibMis);
                if (r_found) begin
                    r_misIdx <= r_firstIdx;
                end else if (w_nibMis) begin
                    r_misIdx <= r_idx;
                end else begin
                    r_misIdx <= '0;
                end
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_compare_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_compare_seq
//
// Purpose:
//   Directed self-checking bench for nibble_compare_seq with NIBBLES=4.
//   Expected results are hand-computed constants. Latency expectations
//   follow CMP_EARLY_EXIT_EN when the bench is built with that macro.
// ---------------------------------------------------------------------------
module tb_nibble_compare_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] aWord;
    logic [15:0] bWord;
    logic        busy;
    logic        done;
    logic        equal;
    logic [1:0]  mismatchIdx;

    int checkCount;
    int failCount;
    int cycleCount;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    nibble_compare_seq #(.NIBBLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a_word       (aWord),
        .b_word       (bWord),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_idx (mismatchIdx)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure how far apart the done pulses are.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Single comparison point. Every comparison in the bench goes through
    // this task.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Applies operands and a one-cycle start pulse, then follows the run to
    // done. It counts busy cycles, can disturb inputs during RUN, and checks
    // that the result is held after done.
    task automatic applyStimulus(input string tag, input logic [15:0] aVal,
                                 input logic [15:0] bVal, input bit disturb,
                                 input int expBusy, input logic expEq,
                                 input logic [1:0] expIdx);
        int busyCycles;
        int guard;
        @(negedge clk);
        aWord = aVal;
        bWord = bVal;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busyCycles = 0;
        guard = 0;
        while (!done && guard < 20) begin
            if (busy) busyCycles++;
            if (disturb && busyCycles == 1) begin
                bWord = aVal;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        start = 1'b0;
        checkOutput({tag, "_done"}, done, 1'b1);
        checkOutput({tag, "_busyCycles"}, busyCycles, expBusy);
        checkOutput({tag, "_busyWithDone"}, busy, 1'b0);
        checkOutput({tag, "_equal"}, equal, expEq);
        checkOutput({tag, "_idx"}, mismatchIdx, expIdx);
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, done, 1'b0);
        checkOutput({tag, "_equalHeld"}, equal, expEq);
        checkOutput({tag, "_idxHeld"}, mismatchIdx, expIdx);
    endtask

    initial begin
        int lastDone;
        int guard;
        logic expEq;
        int expLat;
        checkCount = 0;
        failCount  = 0;
        cycleCount = 0;
        rst_n = 1'b0;
        start = 1'b1;
        aWord = 16'hFFFF;
        bWord = 16'h0000;

        // Reset is held while start is high.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_equal", equal, 1'b0);
        checkOutput("rst_idx", mismatchIdx, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_done", done, 1'b0);
        checkOutput("idle_equal", equal, 1'b0);
        checkOutput("idle_idx", mismatchIdx, 2'd0);

        // Equal operands give a full scan.
        applyStimulus("eq", 16'hA5C3, 16'hA5C3, 1'b0, 4, 1'b1, 2'd0);
        // Mismatch at nibble 1.
        applyStimulus("mis1", 16'h1234, 16'h1274, 1'b0, EARLY ? 2 : 4, 1'b0, 2'd1);
        // Mismatch at nibble 3. b is changed and start is pulsed during RUN.
        applyStimulus("mis3", 16'hF000, 16'h0000, 1'b1, 4, 1'b0, 2'd3);

        // Reset during the second RUN cycle, after an equal result has set
        // equal high.
        applyStimulus("pre", 16'h0F0F, 16'h0F0F, 1'b0, 4, 1'b1, 2'd0);
        @(negedge clk);
        aWord = 16'h1234;
        bWord = 16'h4321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_busyBefore", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_equal", equal, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_noDone", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post", 16'h0F0F, 16'h0F0F, 1'b0, 4, 1'b1, 2'd0);

        // Back-to-back compares with start held high. b alternates between
        // an equal value and a value that mismatches at nibble 0.
        @(negedge clk);
        aWord = 16'h1111;
        bWord = 16'h1111;
        start = 1'b1;
        lastDone = 0;
        for (int k = 0; k < 4; k++) begin
            expEq  = (k % 2 == 0);
            expLat = (EARLY && !expEq) ? 1 : 4;
            if (k == 0) begin
                @(posedge clk);
            end else begin
                repeat (2) @(posedge clk);
            end
            #1;
            checkOutput($sformatf("b2b%0d_accept", k), busy, 1'b1);
            bWord = (k % 2 == 0) ? 16'h1110 : 16'h1111;
            guard = 0;
            while (!done && guard < 12) begin
                @(posedge clk);
                #1;
                guard++;
            end
            checkOutput($sformatf("b2b%0d_latency", k), guard, expLat);
            checkOutput($sformatf("b2b%0d_equal", k), equal, expEq);
            checkOutput($sformatf("b2b%0d_idx", k), mismatchIdx, 2'd0);
            if (k > 0) begin
                checkOutput($sformatf("b2b%0d_period", k), cycleCount - lastDone, expLat + 2);
            end
            lastDone = cycleCount;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
